// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single off-chip data-memory port (256-bit line, enable/ack
//   handshake) between the instruction-fetch cache (p0) and dcache_top (p1).
//   Round-robin grant, one outstanding transaction, and at least one idle
//   cycle between transactions.
//
// Optional build macro:
//   MEM_ARB_GRANT_CNT_EN  - when defined, pN_grants_o count completed
//                           transactions per requester (wrapping, CNT_W bits).
//                           When undefined, both counters are tied to 0.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   pN_enable_i           request from requester N, held high until pN_ack_o
//   pN_write_i            1 = write, 0 = read
//   pN_addr_i/pN_data_i   line address / write data from requester N
//   pN_data_o             read data, valid with pN_ack_o and held afterwards
//   pN_ack_o              transaction-complete pulse to requester N
//   mem_enable_o/...      request side of the memory port
//   mem_data_i/mem_ack_i  memory read data / completion pulse
//   pN_grants_o           completed-transaction counters
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,

  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,

  output logic [CNT_W-1:0]  p0_grants_o,
  output logic [CNT_W-1:0]  p1_grants_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  // Requester served most recently: 0 = p0, 1 = p1. Resets to 1 so p0
  // wins the first simultaneous request.
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    p0_ack_o     = 1'b0;
    p1_ack_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // mem_ack_i is deliberately ignored here.
        if (p0_enable_i && p1_enable_i) begin
          state_d = last_grant_q ? BUSY0 : BUSY1;
        end else if (p0_enable_i) begin
          state_d = BUSY0;
        end else if (p1_enable_i) begin
          state_d = BUSY1;
        end
      end

      // The grant is held even if the requester drops enable before the
      // ack; whatever it currently presents is passed through.
      BUSY0: begin
        mem_enable_o = 1'b1;
        mem_write_o  = p0_write_i;
        mem_addr_o   = p0_addr_i;
        mem_data_o   = p0_data_i;
        if (mem_ack_i) begin
          p0_ack_o     = 1'b1;
          p0_rdata_d   = mem_data_i;
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end

      BUSY1: begin
        mem_enable_o = 1'b1;
        mem_write_o  = p1_write_i;
        mem_addr_o   = p1_addr_i;
        mem_data_o   = p1_data_i;
        if (mem_ack_i) begin
          p1_ack_o     = 1'b1;
          p1_rdata_d   = mem_data_i;
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Read data appears in the ack cycle itself, then stays in the holding
  // register until that requester's next ack.
  assign p0_data_o = p0_rdata_d;
  assign p1_data_o = p1_rdata_d;

`ifdef MEM_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] p0_cnt_q, p1_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
    end else begin
      if (p0_ack_o) p0_cnt_q <= p0_cnt_q + CNT_W'(1);
      if (p1_ack_o) p1_cnt_q <= p1_cnt_q + CNT_W'(1);
    end
  end

  assign p0_grants_o = p0_cnt_q;
  assign p1_grants_o = p1_cnt_q;
`else
  assign p0_grants_o = '0;
  assign p1_grants_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed scenarios followed by
//   randomized requester/memory traffic, all compared every cycle against a
//   transaction-level reference model (current owner, last served requester,
//   held read data, completion counts).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en [2];
  logic              wr [2];
  logic [ADDR_W-1:0] ad [2];
  logic [DATA_W-1:0] wd [2];
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;

  logic [DATA_W-1:0] p0_data_o, p1_data_o, mem_data_o;
  logic              p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [CNT_W-1:0]  p0_grants_o, p1_grants_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .p0_enable_i  (en[0]),
    .p0_write_i   (wr[0]),
    .p0_addr_i    (ad[0]),
    .p0_data_i    (wd[0]),
    .p0_data_o    (p0_data_o),
    .p0_ack_o     (p0_ack_o),
    .p1_enable_i  (en[1]),
    .p1_write_i   (wr[1]),
    .p1_addr_i    (ad[1]),
    .p1_data_i    (wd[1]),
    .p1_data_o    (p1_data_o),
    .p1_ack_o     (p1_ack_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data),
    .mem_ack_i    (mem_ack),
    .p0_grants_o  (p0_grants_o),
    .p1_grants_o  (p1_grants_o)
  );

  // Reference model state.
  int                owner;      // -1 = nobody holds the memory port
  int                last;       // requester served most recently
  logic [DATA_W-1:0] held [2];
  logic [CNT_W-1:0]  done_cnt [2];
  logic              done [2];
  int                busy_cnt;

  // Stimulus control.
  bit                rand_mode;
  bit                pending [2];
  bit                spur;
  int                mem_lat;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_seen [2];
  int dut_order [$];

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_line();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    owner    = -1;
    last     = 1;
    busy_cnt = 0;
    for (int n = 0; n < 2; n++) begin
      held[n]     = '0;
      done_cnt[n] = '0;
      done[n]     = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs that were
  // presented during the cycle that just ended.
  task automatic model_edge();
    done[0] = 1'b0;
    done[1] = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (owner >= 0) begin
      if (mem_ack) begin
        held[owner]     = mem_data;
        done_cnt[owner] = done_cnt[owner] + 1'b1;
        done[owner]     = 1'b1;
        last            = owner;
        owner           = -1;
      end else begin
        busy_cnt++;
      end
    end else begin
      if (en[0] && en[1]) owner = 1 - last;
      else if (en[0])     owner = 0;
      else if (en[1])     owner = 1;
      if (owner >= 0) begin
        busy_cnt = 0;
        if (rand_mode) mem_lat = $urandom_range(4);
      end
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (done[n]) begin
        pending[n] = 1'b0;
        en[n]      = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int n = 0; n < 2; n++) begin
        if (!pending[n] && $urandom_range(3) == 0) begin
          pending[n] = 1'b1;
          wr[n]      = 1'($urandom_range(1));
          ad[n]      = $urandom;
          wd[n]      = rnd_line();
        end
        // Occasional enable drop while pending exercises the protocol
        // violation path as well as a withdrawn request.
        en[n] = pending[n] && ($urandom_range(29) != 0);
      end
      spur      = ($urandom_range(9) == 0);
      mem_rdata = rnd_line();
    end
    mem_ack  = (owner >= 0 && busy_cnt == mem_lat) || (owner < 0 && spur);
    mem_data = mem_rdata;
  endtask

  task automatic compare_all();
    logic              e_en, e_wr;
    logic [ADDR_W-1:0] e_ad;
    logic [DATA_W-1:0] e_wd;
    logic              e_ack [2];
    logic [DATA_W-1:0] e_dat [2];
    logic [CNT_W-1:0]  e_cnt [2];
    e_en = (owner >= 0);
    e_wr = 1'b0;
    e_ad = '0;
    e_wd = '0;
    if (owner >= 0) begin
      e_wr = wr[owner];
      e_ad = ad[owner];
      e_wd = wd[owner];
    end
    for (int n = 0; n < 2; n++) begin
      e_ack[n] = (owner == n) && mem_ack;
      e_dat[n] = e_ack[n] ? mem_data : held[n];
`ifdef MEM_ARB_GRANT_CNT_EN
      e_cnt[n] = done_cnt[n];
`else
      e_cnt[n] = '0;
`endif
    end
    check("mem_enable", DATA_W'(mem_enable_o), DATA_W'(e_en));
    check("mem_write",  DATA_W'(mem_write_o),  DATA_W'(e_wr));
    check("mem_addr",   DATA_W'(mem_addr_o),   DATA_W'(e_ad));
    check("mem_wdata",  mem_data_o,            e_wd);
    check("p0_ack",     DATA_W'(p0_ack_o),     DATA_W'(e_ack[0]));
    check("p1_ack",     DATA_W'(p1_ack_o),     DATA_W'(e_ack[1]));
    check("p0_rdata",   p0_data_o,             e_dat[0]);
    check("p1_rdata",   p1_data_o,             e_dat[1]);
    check("p0_grants",  DATA_W'(p0_grants_o),  DATA_W'(e_cnt[0]));
    check("p1_grants",  DATA_W'(p1_grants_o),  DATA_W'(e_cnt[1]));
    if (p0_ack_o === 1'b1) begin ack_seen[0]++; dut_order.push_back(0); end
    if (p1_ack_o === 1'b1) begin ack_seen[1]++; dut_order.push_back(1); end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    drive();
    #1 compare_all();
  endtask

  // Asynchronous reset taken between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      en[n]      = 1'b0;
      pending[n] = 1'b0;
    end
    spur    = 1'b0;
    mem_ack = 1'b0;
    model_reset();
    #1 compare_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic clear_seen();
    ack_seen[0] = 0;
    ack_seen[1] = 0;
    dut_order.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    rand_mode = 1'b0;
    spur      = 1'b0;
    mem_lat   = 1;
    mem_rdata = '0;
    mem_data  = '0;
    mem_ack   = 1'b0;
    for (int n = 0; n < 2; n++) begin
      en[n] = 1'b0; wr[n] = 1'b0; ad[n] = '0; wd[n] = '0; pending[n] = 1'b0;
    end
    model_reset();
    clear_seen();
    repeat (2) @(negedge clk);
    #1 compare_all();
    rst_n = 1'b1;

    // p1 read, memory answers 10 cycles after enable.
    mem_lat   = 10;
    mem_rdata = {32{8'hA5}};
    wr[1] = 1'b0; ad[1] = 32'h0000_0400; en[1] = 1'b1;
    repeat (16) step();
    check("read_p1_acks", DATA_W'(ack_seen[1]), DATA_W'(1));
    check("read_p0_acks", DATA_W'(ack_seen[0]), DATA_W'(0));
    check("read_p1_data", p1_data_o, {32{8'hA5}});

    // p1 write passthrough.
    clear_seen();
    mem_lat = 3;
    wr[1] = 1'b1; ad[1] = 32'h20; wd[1] = DATA_W'(16'h1234); en[1] = 1'b1;
    repeat (8) step();
    check("write_p1_acks", DATA_W'(ack_seen[1]), DATA_W'(1));

    // Spurious ack while idle.
    clear_seen();
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    check("spur_acks", DATA_W'(ack_seen[0] + ack_seen[1]), DATA_W'(0));

    // Simultaneous requests from reset, repeated twice.
    do_reset();
    clear_seen();
    mem_lat = 2;
    repeat (2) begin
      wr[0] = 1'b0; ad[0] = 32'h100; en[0] = 1'b1;
      wr[1] = 1'b0; ad[1] = 32'h200; en[1] = 1'b1;
      mem_rdata = rnd_line();
      repeat (12) step();
    end
    check("order_len", DATA_W'(dut_order.size()), DATA_W'(4));
    for (int i = 0; i < 4 && i < dut_order.size(); i++)
      check("order", DATA_W'(dut_order[i]), DATA_W'(i % 2));

    // Reset three cycles into BUSY0, then a normal p1 request.
    mem_lat = 20;
    wr[0] = 1'b1; ad[0] = 32'h300; wd[0] = rnd_line(); en[0] = 1'b1;
    for (int i = 0; i < 10 && owner != 0; i++) step();
    check("busy0_reached", DATA_W'(owner == 0), DATA_W'(1));
    repeat (3) step();
    do_reset();
    clear_seen();
    mem_lat = 2;
    wr[1] = 1'b0; ad[1] = 32'h440; en[1] = 1'b1;
    mem_rdata = rnd_line();
    repeat (8) step();
    check("post_rst_p1_acks", DATA_W'(ack_seen[1]), DATA_W'(1));
    check("post_rst_p0_acks", DATA_W'(ack_seen[0]), DATA_W'(0));

    // Five p0 and three p1 transactions from a clean reset.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      int r;
      r = (i < 5) ? 0 : 1;
      wr[r] = 1'($urandom_range(1)); ad[r] = $urandom; wd[r] = rnd_line();
      en[r] = 1'b1;
      mem_rdata = rnd_line();
      repeat (6) step();
    end
`ifdef MEM_ARB_GRANT_CNT_EN
    check("cnt_p0", DATA_W'(p0_grants_o), DATA_W'(5));
    check("cnt_p1", DATA_W'(p1_grants_o), DATA_W'(3));
`else
    check("cnt_p0", DATA_W'(p0_grants_o), DATA_W'(0));
    check("cnt_p1", DATA_W'(p1_grants_o), DATA_W'(0));
`endif

    // Randomized traffic with occasional resets.
    rand_mode = 1'b1;
    repeat (3000) begin
      step();
      if ($urandom_range(599) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single off-chip data-memory port (256-bit line, enable/ack handshake) between the instruction-fetch cache (p0) and dcache_top (p1).
- Sits between the CPU's cache blocks and the Data_Memory model; memory-side ports mirror the CPU's mem_* interface.
- Round-robin grant, one outstanding transaction, mandatory idle cycle between transactions.

Parameters:
ADDR_W, 32, address width
DATA_W, 256, cache-line width
CNT_W, 16, width of grant counters (optional feature)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
p0_enable_i  input  1  p0 request, held high until p0_ack_o
p0_write_i  input  1  p0 write (1) / read (0)
p0_addr_i  input  ADDR_W  p0 line address
p0_data_i  input  DATA_W  p0 write data
p0_data_o  output  DATA_W  p0 read data, valid with p0_ack_o
p0_ack_o  output  1  p0 transaction complete
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as p0, for dcache_top
mem_enable_o  output  1  memory request
mem_write_o  output  1  memory write
mem_addr_o  output  ADDR_W  memory address
mem_data_o  output  DATA_W  memory write data
mem_data_i  input  DATA_W  memory read data
mem_ack_i  input  1  memory completion pulse
p0_grants_o  output  CNT_W  p0 completed-transaction count
p1_grants_o  output  CNT_W  p1 completed-transaction count

Behaviour:
- Reset (rst_i low, async): state=IDLE, last_grant=1 (p0 wins first tie). All outputs 0, counters 0. Deassertion is synchronous to clk_i.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - mem_enable_o=0, both acks 0.
  - Only p0_enable_i high -> BUSY0. Only p1_enable_i high -> BUSY1.
  - Both high -> grant the requester not equal to last_grant.
  - Neither high -> stay in IDLE.
- BUSYn:
  - mem_enable_o=1; mem_write_o, mem_addr_o, mem_data_o driven combinationally from requester n.
  - Other requester's ack is 0 and its data_o holds its last value.
- mem_ack_i=1 in BUSYn, same cycle:
  - pn_ack_o=1.
  - pn_data_o=mem_data_i, registered and held until that requester's next ack.
- Next edge after the ack: state=IDLE, last_grant=n.
  - So mem_enable_o is low for at least one cycle between transactions.
  - Minimum turnaround is therefore memory latency + 1.
- Requester drops enable while in BUSYn before ack: protocol violation. Arbiter stays in BUSYn, keeps mem_enable_o=1, and drives the address/data currently presented.
- mem_ack_i while in IDLE: ignored; no ack is forwarded and no state change.
- Read data is never forwarded to the non-granted requester.
- Latency, IDLE to mem_enable_o: request seen at edge k -> mem_enable_o high from cycle k+1.
- Reset mid-BUSY: immediate return to IDLE and mem_enable_o=0. The memory model must tolerate the aborted request.

Optional Feature:
MEM_ARB_GRANT_CNT_EN
- Defined: pN_grants_o increments by 1 on every cycle where pN_ack_o=1. Counters wrap at 2^CNT_W-1 -> 0 and reset to 0.
- Undefined: counter logic is absent and both pN_grants_o are tied to 0. Port list is unchanged.

Test Plan:
- Read, p1 only:
  - Stimulus: p1 read at addr 0x00000400; memory acks 10 cycles after enable with data 256'hA5...A5.
  - Response: p1_ack_o pulses 1 cycle with p1_data_o=A5...A5. p0_ack_o stays 0. mem_enable_o falls the cycle after the ack.
- Simultaneous requests from reset:
  - Stimulus: p0 and p1 enabled in the same cycle.
  - Response: p0 served first, then p1, with one IDLE cycle between them. On a repeated simultaneous request the grant order is p0, p1, p0, p1.
- Write passthrough:
  - Stimulus: p1 write, addr 0x20, data 256'h1234.
  - Response: mem_write_o=1, mem_addr_o=0x20, mem_data_o=256'h1234 for the whole of BUSY1; p1_ack_o on mem_ack_i.
- Spurious ack:
  - Stimulus: mem_ack_i=1 while IDLE with no requests.
  - Response: no acks, no state change, mem_enable_o=0.
- Reset mid-transaction:
  - Stimulus: rst_i low 3 cycles into BUSY0.
  - Response: mem_enable_o=0 immediately, outputs cleared. After release, a new p1 request is granted normally.
- Counters (macro defined):
  - Stimulus: 5 p0 and 3 p1 transactions.
  - Response: p0_grants_o=5, p1_grants_o=3.
  - With the macro undefined, both counters read 0.
